// File: rtl/bcd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : bcd_pkg                                                          |
// | Brief   : BCD price type, five digits with two implied fractional digits.  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package bcd_pkg;

    localparam int PRICE_DIGITS = 5;

    // 100.00 encodes as 20'h1_00_00
    typedef logic [4*PRICE_DIGITS-1:0] price_t;

endpackage
`default_nettype wire

// File: rtl/ob_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : ob_pkg                                                           |
// | Brief   : Order book command/response types and operand packing helper.    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package ob_pkg;
    import bcd_pkg::*;

    typedef enum logic [1:0] {
        Op_Nop       = 2'd0,
        Op_QryBidAsk = 2'd1,
        Op_Buy       = 2'd2,
        Op_Sell      = 2'd3
    } opcode_t;

    typedef logic [3:0] uid_t;
    typedef logic [7:0] quantity_t;
    typedef logic [1:0] status_t;

    typedef struct packed {
        quantity_t quantity;
        price_t    price;
    } oprand_buy_t;

    typedef struct packed {
        price_t    price;
        quantity_t quantity;
    } oprand_sell_t;

    localparam int OPRAND_W = $bits(oprand_buy_t);
    typedef logic [OPRAND_W-1:0] oprand_t;

    typedef struct packed {
        uid_t    uid;
        opcode_t opcode;
        oprand_t oprand;
    } cmd_t;

    typedef struct packed {
        uid_t    uid;
        status_t status;
    } rsp_t;

    function automatic oprand_t pack_oprand(opcode_t op, quantity_t qty, price_t price);
        oprand_buy_t  buy;
        oprand_sell_t sell;
        oprand_t      result;
        buy.quantity  = qty;
        buy.price     = price;
        sell.price    = price;
        sell.quantity = qty;
        case (op)
            Op_Buy:  result = oprand_t'(buy);
            Op_Sell: result = oprand_t'(sell);
            default: result = '0;
        endcase
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ob_uid_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : ob_uid_fifo                                                       |
// | Brief  : In-order tracker of issued uids awaiting an order book response.  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module ob_uid_fifo
    import ob_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  uid_t                       push_uid,
    input  logic                       pop,
    output uid_t                       head,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(DEPTH-1);
    localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(DEPTH);

    uid_t             mem_q [DEPTH];
    uid_t             mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == c_full_cnt);
    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        w_do_pop  = pop & ~empty;
        // a pop in the same cycle frees the slot a full-queue push needs
        w_do_push = push & (~full | w_do_pop);
        if (w_do_push) begin
            mem_d[wr_ptr_q] = push_uid;
            wr_ptr_d        = (wr_ptr_q == c_last_ptr) ? '0 : wr_ptr_q + 1'b1;
        end
        if (w_do_pop) begin
            rd_ptr_d = (rd_ptr_q == c_last_ptr) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ob_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : ob_driver                                                         |
// | Brief  : Issues host commands to the order book, matches responses by uid. |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module ob_driver
    import ob_pkg::*;
    import bcd_pkg::*;
#(
    parameter int OUTSTANDING_N = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               req_vld,
    input  opcode_t                            req_opcode,
    input  quantity_t                          req_quantity,
    input  price_t                             req_price,
    output logic                               req_rdy,
    output uid_t                               req_uid,
    output logic                               cmd_vld_r,
    output cmd_t                               cmd_r,
    input  logic                               cmd_full_r,
    input  logic                               rsp_vld,
    input  rsp_t                               rsp,
    output logic                               rsp_accept,
    output logic                               cpl_vld,
    output uid_t                               cpl_uid,
    output status_t                            cpl_status,
    input  logic                               cpl_accept,
    output logic                               err_uid_r,
    output logic [$clog2(OUTSTANDING_N+1)-1:0] outstanding_r
);

    localparam int CNT_W = $clog2(OUTSTANDING_N+1);
    localparam logic [CNT_W-1:0] c_max_out = CNT_W'(OUTSTANDING_N);

    uid_t    uid_q, uid_d;
    logic    cmd_vld_q, cmd_vld_d;
    cmd_t    cmd_q, cmd_d;
    logic    cpl_vld_q, cpl_vld_d;
    uid_t    cpl_uid_q, cpl_uid_d;
    status_t cpl_status_q, cpl_status_d;
    logic    err_q, err_d;

    logic    w_issue;
    logic    w_rsp_take;
    logic    w_pop;
    uid_t    w_head;
    logic    w_empty;
    logic    w_full;

    assign req_rdy    = ~cmd_full_r & (outstanding_r < c_max_out) & ~err_q;
    assign req_uid    = uid_q;
    assign rsp_accept = ~cpl_vld_q | cpl_accept;
    assign w_issue    = req_vld & req_rdy;
    assign w_rsp_take = rsp_vld & rsp_accept;
    assign w_pop      = w_rsp_take & ~w_empty;

    ob_uid_fifo #(
        .DEPTH (OUTSTANDING_N)
    ) u_tracker (
        .clk      (clk),
        .rst      (rst),
        .push     (w_issue),
        .push_uid (uid_q),
        .pop      (w_pop),
        .head     (w_head),
        .empty    (w_empty),
        .full     (w_full),
        .count    (outstanding_r)
    );

    always_comb begin
        uid_d        = uid_q;
        cmd_vld_d    = w_issue;
        cmd_d        = cmd_q;
        cpl_vld_d    = cpl_vld_q;
        cpl_uid_d    = cpl_uid_q;
        cpl_status_d = cpl_status_q;
        err_d        = err_q;
        if (w_issue) begin
            uid_d        = uid_q + uid_t'(1);
            cmd_d.uid    = uid_q;
            cmd_d.opcode = req_opcode;
            cmd_d.oprand = pack_oprand(req_opcode, req_quantity, req_price);
        end
        // completion is forwarded even for an out-of-order or unexpected uid
        if (w_rsp_take) begin
            cpl_vld_d    = 1'b1;
            cpl_uid_d    = rsp.uid;
            cpl_status_d = rsp.status;
            if (w_empty || (rsp.uid != w_head)) begin
                err_d = 1'b1;
            end
        end else if (cpl_accept) begin
            cpl_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uid_q        <= '0;
            cmd_vld_q    <= 1'b0;
            cmd_q        <= '0;
            cpl_vld_q    <= 1'b0;
            cpl_uid_q    <= '0;
            cpl_status_q <= '0;
            err_q        <= 1'b0;
        end else begin
            uid_q        <= uid_d;
            cmd_vld_q    <= cmd_vld_d;
            cmd_q        <= cmd_d;
            cpl_vld_q    <= cpl_vld_d;
            cpl_uid_q    <= cpl_uid_d;
            cpl_status_q <= cpl_status_d;
            err_q        <= err_d;
        end
    end

    assign cmd_vld_r  = cmd_vld_q;
    assign cmd_r      = cmd_q;
    assign cpl_vld    = cpl_vld_q;
    assign cpl_uid    = cpl_uid_q;
    assign cpl_status = cpl_status_q;
    assign err_uid_r  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ob_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_ob_driver                                                      |
// | Brief  : Directed and random stimulus against a queue-based reference.     |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_ob_driver;
    import ob_pkg::*;
    import bcd_pkg::*;

    localparam int OUTSTANDING_N = 4;
    localparam int UID_MOD       = 1 << $bits(uid_t);

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    logic      req_vld = 1'b0;
    opcode_t   req_opcode = Op_Nop;
    quantity_t req_quantity = '0;
    price_t    req_price = '0;
    logic      req_rdy;
    uid_t      req_uid;
    logic      cmd_vld_r;
    cmd_t      cmd_r;
    logic      cmd_full_r = 1'b0;
    logic      rsp_vld = 1'b0;
    rsp_t      rsp = '0;
    logic      rsp_accept;
    logic      cpl_vld;
    uid_t      cpl_uid;
    status_t   cpl_status;
    logic      cpl_accept = 1'b1;
    logic      err_uid_r;
    logic [$clog2(OUTSTANDING_N+1)-1:0] outstanding_r;

    int compared   = 0;
    int mismatched = 0;

    // reference state: what the host should observe, in plain terms
    uid_t        m_q[$];
    int unsigned m_uid;
    bit          m_err;
    bit          m_cmd_vld;
    logic [63:0] m_cmd;
    bit          m_cpl_vld;
    int unsigned m_cpl_uid;
    int unsigned m_cpl_status;

    ob_driver #(.OUTSTANDING_N(OUTSTANDING_N)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_vld       (req_vld),
        .req_opcode    (req_opcode),
        .req_quantity  (req_quantity),
        .req_price     (req_price),
        .req_rdy       (req_rdy),
        .req_uid       (req_uid),
        .cmd_vld_r     (cmd_vld_r),
        .cmd_r         (cmd_r),
        .cmd_full_r    (cmd_full_r),
        .rsp_vld       (rsp_vld),
        .rsp           (rsp),
        .rsp_accept    (rsp_accept),
        .cpl_vld       (cpl_vld),
        .cpl_uid       (cpl_uid),
        .cpl_status    (cpl_status),
        .cpl_accept    (cpl_accept),
        .err_uid_r     (err_uid_r),
        .outstanding_r (outstanding_r)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Buy carries quantity above price, Sell carries price above quantity
    function automatic logic [63:0] expect_cmd(int unsigned uid, opcode_t op,
                                               quantity_t qty, price_t pr);
        logic [63:0] operand;
        logic [63:0] word;
        case (op)
            Op_Buy:  operand = (64'(qty) << $bits(price_t)) | 64'(pr);
            Op_Sell: operand = (64'(pr) << $bits(quantity_t)) | 64'(qty);
            default: operand = 64'd0;
        endcase
        word = (64'(uid) << ($bits(opcode_t) + OPRAND_W))
             | (64'(op) << OPRAND_W) | operand;
        return word;
    endfunction

    task automatic check_regs();
        check("cmd_vld_r", 64'(cmd_vld_r), 64'(m_cmd_vld));
        check("cmd_r", 64'(cmd_r), m_cmd);
        check("cpl_vld", 64'(cpl_vld), 64'(m_cpl_vld));
        check("cpl_uid", 64'(cpl_uid), 64'(m_cpl_uid));
        check("cpl_status", 64'(cpl_status), 64'(m_cpl_status));
        check("err_uid_r", 64'(err_uid_r), 64'(m_err));
        check("outstanding_r", 64'(outstanding_r), 64'(m_q.size()));
    endtask

    task automatic step(input logic vld, input opcode_t op, input quantity_t qty,
                        input price_t pr, input logic full, input logic rv,
                        input uid_t ruid, input status_t rs, input logic cacc);
        bit exp_rdy, exp_racc, issue, take;
        @(negedge clk);
        check_regs();
        req_vld      = vld;
        req_opcode   = op;
        req_quantity = qty;
        req_price    = pr;
        cmd_full_r   = full;
        rsp_vld      = rv;
        rsp.uid      = ruid;
        rsp.status   = rs;
        cpl_accept   = cacc;
        #1;
        exp_rdy  = !full && (m_q.size() < OUTSTANDING_N) && !m_err;
        exp_racc = !m_cpl_vld || cacc;
        check("req_rdy", 64'(req_rdy), 64'(exp_rdy));
        check("rsp_accept", 64'(rsp_accept), 64'(exp_racc));
        check("req_uid", 64'(req_uid), 64'(m_uid));
        issue = vld && exp_rdy;
        take  = rv && exp_racc;
        if (take) begin
            if (m_q.size() == 0 || m_q[0] != ruid) m_err = 1'b1;
            if (m_q.size() > 0) void'(m_q.pop_front());
            m_cpl_vld    = 1'b1;
            m_cpl_uid    = ruid;
            m_cpl_status = rs;
        end else if (cacc) begin
            m_cpl_vld = 1'b0;
        end
        m_cmd_vld = issue;
        if (issue) begin
            m_cmd = expect_cmd(m_uid, op, qty, pr);
            m_q.push_back(uid_t'(m_uid));
            m_uid = (m_uid + 1) % UID_MOD;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, Op_Nop, '0, '0, 0, 0, '0, '0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        req_vld    = 1'b0;
        rsp_vld    = 1'b0;
        cmd_full_r = 1'b0;
        cpl_accept = 1'b1;
        #2;
        m_q.delete();
        m_uid = 0; m_err = 0; m_cmd_vld = 0; m_cmd = '0;
        m_cpl_vld = 0; m_cpl_uid = 0; m_cpl_status = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic respond_head(input status_t rs, input logic cacc);
        step(0, Op_Nop, '0, '0, 0, 1, m_q[0], rs, cacc);
    endtask

    initial begin
        // reset values, then a single Buy 10 @ 100.00
        do_reset();
        step(1, Op_Buy, 8'd10, 20'h10000, 0, 0, '0, '0, 1);
        idle(1);

        // fill the tracker, stall, then free a slot
        do_reset();
        for (int i = 0; i < 4; i++) step(1, Op_Sell, 8'(i + 3), 20'h00250, 0, 0, '0, '0, 1);
        step(1, Op_QryBidAsk, 8'd1, 20'h00001, 0, 0, '0, '0, 1);
        respond_head(2'd1, 1);
        step(1, Op_Buy, 8'd7, 20'h09999, 0, 0, '0, '0, 1);
        idle(1);

        // order book queue full for three cycles with a request pending
        do_reset();
        for (int i = 0; i < 3; i++) step(1, Op_Buy, 8'd5, 20'h00500, 1, 0, '0, '0, 1);
        step(1, Op_Buy, 8'd5, 20'h00500, 0, 0, '0, '0, 1);
        step(1, Op_Sell, 8'd6, 20'h00600, 0, 0, '0, '0, 1);
        idle(1);

        // completion back-pressure: second response held until accepted
        respond_head(2'd2, 0);
        step(0, Op_Nop, '0, '0, 0, 1, m_q[0], 2'd3, 0);
        step(0, Op_Nop, '0, '0, 0, 1, m_q[0], 2'd3, 0);
        step(0, Op_Nop, '0, '0, 0, 1, m_q[0], 2'd3, 1);
        idle(2);

        // uid wrap with immediate responses
        do_reset();
        for (int i = 0; i < UID_MOD + 2; i++) begin
            step(i <= UID_MOD, Op_Buy, 8'(i), 20'(i), 0, m_q.size() > 0,
                 (m_q.size() > 0) ? m_q[0] : uid_t'(0), 2'd0, 1);
        end
        idle(2);

        // wrong uid: head is 2, response carries 5
        do_reset();
        for (int i = 0; i < 3; i++) step(1, Op_Buy, 8'd1, 20'h00100, 0, 0, '0, '0, 1);
        respond_head(2'd0, 1);
        respond_head(2'd0, 1);
        step(1, Op_Buy, 8'd1, 20'h00100, 0, 1, uid_t'(5), 2'd1, 1);
        for (int i = 0; i < 3; i++) step(1, Op_Buy, 8'd1, 20'h00100, 0, 0, '0, '0, 1);

        // reset mid-flight discards tracking; a late response is unexpected
        do_reset();
        step(1, Op_Sell, 8'd2, 20'h00200, 0, 0, '0, '0, 1);
        step(1, Op_Sell, 8'd3, 20'h00300, 0, 0, '0, '0, 1);
        do_reset();
        step(0, Op_Nop, '0, '0, 0, 1, uid_t'(0), 2'd2, 1);
        idle(2);

        // random traffic with well-ordered responses
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic rv;
            rv = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
            step($urandom_range(0, 3) != 0, opcode_t'($urandom_range(0, 3)),
                 quantity_t'($urandom), price_t'($urandom),
                 $urandom_range(0, 4) == 0, rv,
                 (m_q.size() > 0) ? m_q[0] : uid_t'(0),
                 status_t'($urandom_range(0, 3)), $urandom_range(0, 2) != 0);
        end
        idle(1);
        @(negedge clk);
        check_regs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ob_driver.md
OB_DRIVER -- requirements
Module: ob_driver

Interface
REQ-001 Parameter OUTSTANDING_N, default 4, max commands issued to the order book without a response yet.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_vld  input  1  host presents a command.
REQ-005 req_opcode  input  ob_pkg::opcode_t  Op_Nop/Op_QryBidAsk/Op_Buy/Op_Sell.
REQ-006 req_quantity  input  ob_pkg::quantity_t  buy/sell quantity.
REQ-007 req_price  input  bcd_pkg::price_t  buy/sell price.
REQ-008 req_rdy  output  1  host command accepted when req_vld & req_rdy.
REQ-009 req_uid  output  ob_pkg::uid_t  uid assigned to the command accepted this cycle.
REQ-010 cmd_vld_r  output  1  registered command strobe to order book.
REQ-011 cmd_r  output  ob_pkg::cmd_t  registered command; oprand packed as oprand_buy_t/oprand_sell_t per opcode, zero for Nop/QryBidAsk.
REQ-012 cmd_full_r  input  1  order book command queue full.
REQ-013 rsp_vld  input  1  order book response valid.
REQ-014 rsp  input  ob_pkg::rsp_t  response (uid, status).
REQ-015 rsp_accept  output  1  response consumed when rsp_vld & rsp_accept.
REQ-016 cpl_vld / cpl_uid / cpl_status  output  1 / uid_t / status_t  registered completion to host.
REQ-017 cpl_accept  input  1  host consumes completion.
REQ-018 err_uid_r  output  1  sticky: response uid did not match oldest outstanding uid.
REQ-019 outstanding_r  output  $clog2(OUTSTANDING_N+1)  commands in flight.

Function
REQ-020 req_rdy SHALL equal ~cmd_full_r & (outstanding_r < OUTSTANDING_N) & ~err_uid_r, combinational.
REQ-021 On req_vld & req_rdy: cmd_r loaded next edge, cmd_vld_r=1 for exactly one cycle, cmd_r.uid = uid counter value; req_uid shows that value same cycle.
REQ-022 uid counter SHALL increment by 1 per accepted command, wrapping modulo 2^width(uid_t); reset value 0.
REQ-023 cmd_vld_r SHALL be 0 in any cycle following one where cmd_full_r=1; back-to-back issue allowed while cmd_full_r=0.
REQ-024 When cmd_vld_r=0, cmd_r holds its last value (no toggling).
REQ-025 Each issued uid SHALL be pushed into an in-order tracking FIFO of depth OUTSTANDING_N.
REQ-026 rsp_accept SHALL equal ~cpl_vld | cpl_accept (single-entry completion register with pass-through on drain).
REQ-027 On rsp_vld & rsp_accept: pop tracker head; load cpl_uid/cpl_status from rsp; cpl_vld=1 next cycle.
REQ-028 If rsp.uid != tracker head, or response arrives with tracker empty: set err_uid_r (sticky until reset), still forward completion, pop only if non-empty.
REQ-029 Simultaneous issue and response in one cycle: outstanding_r unchanged; push and pop both performed.
REQ-030 cpl_vld cleared on cpl_accept unless a new response is loaded same cycle.
REQ-031 Latency: host request to cmd_vld_r = 1 cycle; rsp to cpl_vld = 1 cycle.

Reset
REQ-032 On rst: cmd_vld_r=0, cmd_r='0, cpl_vld=0, cpl_uid='0, cpl_status='0, uid counter 0, tracker empty, outstanding_r=0, err_uid_r=0.
REQ-033 Reset asserted mid-operation SHALL discard in-flight tracking; responses after reset release are treated per REQ-028.

Structure
REQ-034 opcode_t, uid_t, quantity_t, cmd_t, rsp_t, status_t, oprand_buy_t, oprand_sell_t SHALL come from ob_pkg; price_t from bcd_pkg; no new typedefs local to the module.
REQ-035 Tracker SHALL be a sub-module ob_uid_fifo (parameterised depth, push/pop/head/empty/full).

Verification
REQ-036 Reset, then Buy qty=10 price=100.00 -> cmd_vld_r one cycle later with uid=0, oprand matches; outstanding_r=1.
REQ-037 Issue 4 commands, no responses -> req_rdy=0 with outstanding_r=4; response uid=0 -> cpl_vld next cycle, req_rdy=1.
REQ-038 cmd_full_r=1 held 3 cycles while req_vld=1 -> no cmd_vld_r during those cycles; issue resumes cycle after deassert.
REQ-039 cpl_accept=0 with completion pending and second rsp_vld -> rsp_accept=0 until cpl_accept=1; no response lost.
REQ-040 Response uid=5 when head is 2 -> err_uid_r=1 sticky, req_rdy=0 until rst.
REQ-041 Issue 2^width(uid_t)+1 commands with immediate responses -> uid wraps to 0, err_uid_r stays 0.
